// File: rtl/keypad_decoder.sv
// 4x4 keypad decoder: debounced press/release detection against the column scan index.
// Optional auto-repeat of KeyValid while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_CYCLES   = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] Col,
  input  logic [3:0] Rows,
  output logic       ScanEn,
  output logic [3:0] KeyCode,
  output logic       KeyValid,
  output logic       KeyHeld
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("keypad_decoder: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 1");
  end

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    StScan,
    StDebounce,
    StEmit,
    StHold,
    StRelease
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      cand_row_q;
  logic [1:0]      cand_col_q;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYCLES - 1);
  logic [RepW-1:0] rep_q;
`endif

  logic       any_low;
  logic       cand_high;
  logic [1:0] row_idx;

  // Fixed priority: row 0 wins when several rows are low.
  always_comb begin
    row_idx = 2'd3;
    if (!Rows[0]) begin
      row_idx = 2'd0;
    end else if (!Rows[1]) begin
      row_idx = 2'd1;
    end else if (!Rows[2]) begin
      row_idx = 2'd2;
    end
  end

  assign any_low   = (Rows != 4'hF);
  assign cand_high = Rows[cand_row_q];

  // Combinational so the scan counter freezes on the edge the press is first sampled.
  assign ScanEn = (state_q == StScan) && !any_low;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= StScan;
      cnt_q      <= '0;
      cand_row_q <= '0;
      cand_col_q <= '0;
      KeyCode    <= '0;
      KeyValid   <= 1'b0;
      KeyHeld    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q      <= '0;
`endif
    end else begin
      KeyValid <= 1'b0;
      case (state_q)
        StScan: begin
          if (any_low) begin
            cand_row_q <= row_idx;
            cand_col_q <= Col;
            cnt_q      <= CntW'(1);
            if (DEBOUNCE_CYCLES == 1) begin
              state_q  <= StEmit;
              KeyCode  <= {row_idx, Col};
              KeyValid <= 1'b1;
              KeyHeld  <= 1'b1;
            end else begin
              state_q <= StDebounce;
            end
          end
        end
        StDebounce: begin
          if (cand_high || (Col != cand_col_q)) begin
            state_q <= StScan;
          end else if (cnt_q >= CntLast) begin
            // This sample completes the stable run, so the code is emitted on this edge.
            state_q  <= StEmit;
            KeyCode  <= {cand_row_q, cand_col_q};
            KeyValid <= 1'b1;
            KeyHeld  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StEmit: begin
          state_q <= StHold;
`ifdef KEYPAD_REPEAT_EN
          rep_q   <= '0;
`endif
        end
        StHold: begin
          if (cand_high) begin
            cnt_q <= CntW'(1);
`ifdef KEYPAD_REPEAT_EN
            rep_q <= '0;
`endif
            if (DEBOUNCE_CYCLES == 1) begin
              KeyHeld <= 1'b0;
              state_q <= StScan;
            end else begin
              state_q <= StRelease;
            end
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if (rep_q >= RepLast) begin
              KeyValid <= 1'b1;
              rep_q    <= '0;
            end else begin
              rep_q <= rep_q + 1'b1;
            end
`endif
          end
        end
        StRelease: begin
          if (!cand_high) begin
            cnt_q <= '0;
          end else if (cnt_q >= CntLast) begin
            KeyHeld <= 1'b0;
            state_q <= StScan;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StScan;
        end
      endcase
    end
  end

endmodule
